// File: rtl/ppi_bus_pkg.sv
// Shared types and constants for the 8255 PPI bus initiator.
package ppi_bus_pkg;

  localparam int unsigned CNT_W         = 4;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned ADDR_W        = 2;
  localparam int unsigned CTRL_MODE_BIT = 7;

  localparam logic [ADDR_W-1:0] ADDR_PA   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_PB   = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_PC   = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_CTRL = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // The control register is write-only on the PPI, so reading it is rejected.
  function automatic logic is_rejected(input logic write, input logic [ADDR_W-1:0] addr);
    return !write && (addr == ADDR_CTRL);
  endfunction

endpackage

// File: rtl/ppi_phase_timer.sv
// Loadable down-counter that times each bus phase; expire is high while value is 1.
module ppi_phase_timer
  import ppi_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_next;

  // Counts down to 1 and parks there until reloaded.
  always_comb begin
    cnt_next = value;
    if (load) begin
      cnt_next = load_val;
    end else if (value > CNT_W'(1)) begin
      cnt_next = value - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value  <= '0;
      expire <= 1'b0;
    end else begin
      value  <= cnt_next;
      expire <= (cnt_next == CNT_W'(1));
    end
  end

endmodule

// File: rtl/ppi_bus_master.sv
// Host-side initiator producing timed CS/RD/WR/A/D cycles toward an 8255 PPI.
module ppi_bus_master
  import ppi_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              CS,
  output logic              RD,
  output logic              WR,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D_out,
  output logic              D_oe,
  input  logic [DATA_W-1:0] D_in,
  output logic [DATA_W-1:0] ctrl_shadow,
  output logic              ctrl_valid
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
      HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_timing
    $error("ppi_bus_master: SETUP_CYC/STROBE_CYC/HOLD_CYC must be in 1..15");
  end

  state_e            state_q, state_d;
  req_t              lat_q, lat_d;
  logic              cs_d, rd_d, wr_d, oe_d, ready_d;
  logic              rspv_d, rspw_d, rspe_d, cvalid_d;
  logic [ADDR_W-1:0] a_d;
  logic [DATA_W-1:0] dout_d, rdata_d, shadow_d;
  logic              tmr_load, tmr_expire;
  logic [CNT_W-1:0]  tmr_val, tmr_value;
  logic              accept;

  assign accept = req_valid && req_ready;

  ppi_phase_timer u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .expire   (tmr_expire)
  );

  // Next-state and next-output logic; bus outputs are registered from these.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    cs_d     = 1'b1;
    rd_d     = 1'b1;
    wr_d     = 1'b1;
    oe_d     = 1'b0;
    a_d      = A;
    dout_d   = D_out;
    ready_d  = 1'b0;
    rspv_d   = 1'b0;
    rspw_d   = rsp_write;
    rspe_d   = rsp_err;
    rdata_d  = rsp_rdata;
    shadow_d = ctrl_shadow;
    cvalid_d = ctrl_valid;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          lat_d   = '{write: req_write, addr: req_addr, wdata: req_wdata};
          rdata_d = '0;
          if (is_rejected(req_write, req_addr)) begin
            rspv_d = 1'b1;
            rspw_d = req_write;
            rspe_d = 1'b1;
          end else begin
            state_d  = SETUP;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(SETUP_CYC);
            ready_d  = 1'b0;
            cs_d     = 1'b0;
            a_d      = req_addr;
            oe_d     = req_write;
            if (req_write) begin
              dout_d = req_wdata;
            end
          end
        end
      end

      SETUP: begin
        cs_d = 1'b0;
        oe_d = lat_q.write;
        if (tmr_expire) begin
          state_d  = STROBE;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(STROBE_CYC);
          wr_d     = !lat_q.write;
          rd_d     = lat_q.write;
        end
      end

      STROBE: begin
        cs_d = 1'b0;
        oe_d = lat_q.write;
        wr_d = !lat_q.write;
        rd_d = lat_q.write;
        if (tmr_expire) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(HOLD_CYC);
          wr_d     = 1'b1;
          rd_d     = 1'b1;
          // RD is still low at this edge, so the PPI is still driving D_in.
          if (!lat_q.write) begin
            rdata_d = D_in;
          end
        end
      end

      HOLD: begin
        cs_d = 1'b0;
        oe_d = lat_q.write;
        if (tmr_expire) begin
          state_d = IDLE;
          cs_d    = 1'b1;
          oe_d    = 1'b0;
          ready_d = 1'b1;
          rspv_d  = 1'b1;
          rspw_d  = lat_q.write;
          rspe_d  = 1'b0;
          if (lat_q.write && lat_q.addr == ADDR_CTRL && lat_q.wdata[CTRL_MODE_BIT]) begin
            shadow_d = lat_q.wdata;
            cvalid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      CS          <= 1'b1;
      RD          <= 1'b1;
      WR          <= 1'b1;
      A           <= '0;
      D_out       <= '0;
      D_oe        <= 1'b0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      ctrl_shadow <= '0;
      ctrl_valid  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      CS          <= cs_d;
      RD          <= rd_d;
      WR          <= wr_d;
      A           <= a_d;
      D_out       <= dout_d;
      D_oe        <= oe_d;
      req_ready   <= ready_d;
      rsp_valid   <= rspv_d;
      rsp_write   <= rspw_d;
      rsp_err     <= rspe_d;
      rsp_rdata   <= rdata_d;
      ctrl_shadow <= shadow_d;
      ctrl_valid  <= cvalid_d;
    end
  end

  a_timer_live: assert property (@(posedge CLK) disable iff (RST)
    (state_q != IDLE) |-> (tmr_value != '0));

endmodule

// File: tb/tb_ppi_bus_master.sv
// Scoreboard bench for ppi_bus_master with a behavioural PPI device on the bus.
module tb_ppi_bus_master;

  localparam int S_CYC  = 1;
  localparam int ST_CYC = 2;
  localparam int H_CYC  = 1;
  localparam int LAT    = S_CYC + ST_CYC + H_CYC + 1;

  logic       CLK = 1'b0;
  logic       RST;
  logic       req_valid, req_ready, req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_write, rsp_err;
  logic [7:0] rsp_rdata;
  logic       CS, RD, WR, D_oe, ctrl_valid;
  logic [1:0] A;
  logic [7:0] D_out, D_in, ctrl_shadow;

  ppi_bus_master #(
    .SETUP_CYC  (S_CYC),
    .STROBE_CYC (ST_CYC),
    .HOLD_CYC   (H_CYC)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_write   (rsp_write),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .CS          (CS),
    .RD          (RD),
    .WR          (WR),
    .A           (A),
    .D_out       (D_out),
    .D_oe        (D_oe),
    .D_in        (D_in),
    .ctrl_shadow (ctrl_shadow),
    .ctrl_valid  (ctrl_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       w;
    logic [1:0] a;
    logic       err;
    logic [7:0] rdata;
    logic [7:0] sh;
    logic       cv;
    int         due;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] ref_mem [4];
  logic [7:0] ref_sh;
  logic       ref_cv;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  function automatic logic [7:0] init_val(input int i);
    case (i)
      0: return 8'h12;
      1: return 8'h99;
      2: return 8'h5A;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // PPI device: port latches written while WR is low, driven onto D_in while RD is low.
  logic [7:0] dev_mem [4];
  bit         dev_wr [4];
  always @(posedge CLK) begin
    if (!RST && !CS && !WR) begin
      dev_mem[A] = D_out;
      dev_wr[A]  = 1'b1;
    end
  end
  assign D_in = (!CS && !RD) ? (dev_wr[A] ? dev_mem[A] : init_val(int'(A))) : 8'h00;

  // Reference model: expected response computed when the request is accepted.
  function automatic void push_exp();
    exp_t x;
    x.w     = req_write;
    x.a     = req_addr;
    x.err   = !req_write && (req_addr == 2'd3);
    x.rdata = (req_write || x.err) ? 8'h00 : ref_mem[req_addr];
    x.due   = cyc + (x.err ? 1 : LAT);
    if (req_write) begin
      ref_mem[req_addr] = req_wdata;
      if (req_addr == 2'd3 && req_wdata[7]) begin
        ref_sh = req_wdata;
        ref_cv = 1'b1;
      end
    end
    x.sh = ref_sh;
    x.cv = ref_cv;
    sb.push_back(x);
  endfunction

  // Monitor: response scoreboard plus per-transaction bus shape checks.
  int cs_run = 0, hi_run = 0, st_run = 0, pre_st = 0, last_gap = 0, cs_starts = 0;
  bit prev_cs = 1'b1, ovl = 1'b0, oe_bad = 1'b0, kind_bad = 1'b0, a_bad = 1'b0, idle_bad = 1'b0;
  logic cur_w;
  logic [1:0] cur_a;

  always @(negedge CLK) begin
    if (RST) begin
      prev_cs = 1'b1; cs_run = 0; hi_run = 0; st_run = 0; pre_st = 0;
      ovl = 1'b0; oe_bad = 1'b0; kind_bad = 1'b0; a_bad = 1'b0; idle_bad = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_write", int'(rsp_write), int'(e.w));
          chk("rsp_err", int'(rsp_err), int'(e.err));
          chk("rsp_rdata", int'(rsp_rdata), int'(e.rdata));
          chk("rsp_latency", cyc, e.due);
          chk("ctrl_shadow", int'(ctrl_shadow), int'(e.sh));
          chk("ctrl_valid", int'(ctrl_valid), int'(e.cv));
        end
      end
      if (!CS) begin
        if (prev_cs) begin
          chk("idle_bus_quiet", int'(idle_bad), 0);
          cs_starts++;
          last_gap = hi_run;
          cs_run = 0; st_run = 0; pre_st = 0;
          ovl = 1'b0; oe_bad = 1'b0; kind_bad = 1'b0; a_bad = 1'b0;
        end
        cs_run++;
        cur_w = (sb.size() > 0) ? sb[0].w : 1'b0;
        cur_a = (sb.size() > 0) ? sb[0].a : 2'd0;
        if (!RD && !WR) ovl = 1'b1;
        if (D_oe !== cur_w) oe_bad = 1'b1;
        if (A !== cur_a) a_bad = 1'b1;
        if (cur_w ? !RD : !WR) kind_bad = 1'b1;
        if (!RD || !WR) begin
          if (st_run == 0) pre_st = cs_run - 1;
          st_run++;
        end
        prev_cs = 1'b0;
      end else begin
        if (!prev_cs) begin
          chk("cs_low_cycles", cs_run, S_CYC + ST_CYC + H_CYC);
          chk("strobe_cycles", st_run, ST_CYC);
          chk("setup_cycles", pre_st, S_CYC);
          chk("rd_wr_overlap", int'(ovl), 0);
          chk("d_oe_in_cycle", int'(oe_bad), 0);
          chk("addr_in_cycle", int'(a_bad), 0);
          chk("wrong_strobe", int'(kind_bad), 0);
          hi_run = 0;
          idle_bad = 1'b0;
        end
        hi_run++;
        if (D_oe || !RD || !WR) idle_bad = 1'b1;
        prev_cs = 1'b1;
      end
    end
  end

  // Issue one request; fields may be scrambled while stalled since only the accepted values count.
  task automatic do_req(input logic w, input logic [1:0] a, input logic [7:0] d,
                        input bit hold, input bit scramble, output int acc);
    int guard;
    bit ok;
    guard = 0;
    ok = 1'b0;
    acc = -1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!ok && guard <= 40) begin
      @(negedge CLK);
      if (req_ready) begin
        ok = 1'b1;
      end else begin
        guard++;
        if (scramble) begin
          req_write = 1'($urandom);
          req_addr  = 2'($urandom);
          req_wdata = 8'($urandom);
        end
      end
    end
    if (ok) begin
      push_exp();
      acc = cyc;
      @(posedge CLK);
      #1;
    end else begin
      chk("accept_timeout", 0, 1);
    end
    if (!hold || !ok) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc1, acc2, g, gaps;
    bit   seen;
    logic w;
    logic [1:0] a;
    logic [7:0] d;
    bit   hold;

    RST = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 2'd0; req_wdata = 8'h00;
    for (int i = 0; i < 4; i++) ref_mem[i] = init_val(i);
    ref_sh = 8'h00;
    ref_cv = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cs", int'(CS), 1);
    chk("rst_rd", int'(RD), 1);
    chk("rst_wr", int'(WR), 1);
    chk("rst_a", int'(A), 0);
    chk("rst_d_out", int'(D_out), 0);
    chk("rst_d_oe", int'(D_oe), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_write", int'(rsp_write), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_rsp_rdata", int'(rsp_rdata), 0);
    chk("rst_ctrl_shadow", int'(ctrl_shadow), 0);
    chk("rst_ctrl_valid", int'(ctrl_valid), 0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    do_req(1'b1, 2'd3, 8'h80, 1'b0, 1'b0, acc1);
    wait_idle();
    chk("mode_word_shadow", int'(ctrl_shadow), 8'h80);
    chk("mode_word_valid", int'(ctrl_valid), 1);

    do_req(1'b0, 2'd1, 8'h00, 1'b0, 1'b0, acc1);
    wait_idle();

    do_req(1'b1, 2'd3, 8'h0F, 1'b0, 1'b0, acc1);
    wait_idle();
    chk("bsr_keeps_shadow", int'(ctrl_shadow), 8'h80);

    g = cs_starts;
    do_req(1'b0, 2'd3, 8'h00, 1'b0, 1'b0, acc1);
    wait_idle();
    chk("err_read_no_cs", cs_starts - g, 0);

    do_req(1'b1, 2'd0, 8'h55, 1'b1, 1'b0, acc1);
    do_req(1'b1, 2'd2, 8'hAA, 1'b0, 1'b0, acc2);
    wait_idle();
    chk("b2b_accept_cycle", acc2, acc1 + LAT);
    chk("b2b_cs_gap", last_gap, 1);
    do_req(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, acc1);
    do_req(1'b0, 2'd2, 8'h00, 1'b0, 1'b0, acc1);
    wait_idle();

    for (int i = 0; i < 80; i++) begin
      w    = 1'($urandom);
      a    = 2'($urandom);
      d    = 8'($urandom);
      hold = ($urandom_range(0, 2) == 0);
      do_req(w, a, d, hold, 1'b1, acc1);
      if (!hold) begin
        gaps = $urandom_range(0, 3);
        repeat (gaps) begin
          @(posedge CLK);
          #1;
        end
      end
    end
    req_valid = 1'b0;
    wait_idle();

    do_req(1'b1, 2'd3, 8'hC3, 1'b0, 1'b0, acc1);
    wait_idle();
    do_req(1'b1, 2'd1, 8'h77, 1'b0, 1'b0, acc1);
    g = 0;
    while (WR && g < 20) begin
      @(negedge CLK);
      g++;
    end
    chk("abort_wr_seen", int'(WR), 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("abort_cs", int'(CS), 1);
    chk("abort_wr", int'(WR), 1);
    chk("abort_rd", int'(RD), 1);
    chk("abort_d_oe", int'(D_oe), 0);
    chk("abort_ctrl_valid", int'(ctrl_valid), 0);
    chk("abort_ctrl_shadow", int'(ctrl_shadow), 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (rsp_valid) seen = 1'b1;
    end
    chk("abort_no_rsp", int'(seen), 0);
    sb.delete();
    ref_sh = 8'h00;
    ref_cv = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    do_req(1'b0, 2'd1, 8'h00, 1'b0, 1'b0, acc1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
